// File: rtl/cu_pkg.sv
// cu_pkg: shared state, code and control-word types for the immediate-class control unit
package cu_pkg;
  typedef enum logic [1:0] {IDLE, EX0, EX1} state_t;
  localparam logic [4:0] FS_AND  = 5'b00000;
  localparam logic [4:0] FS_ANDN = 5'b00001;
  localparam logic [4:0] FS_NOTA = 5'b00011;
  localparam logic [4:0] FS_ORR  = 5'b00100;
  localparam logic [4:0] FS_ADD  = 5'b01000;
  localparam logic [4:0] FS_SUB  = 5'b01001;
  localparam logic [4:0] FS_XOR  = 5'b01100;
  localparam logic [4:0] FS_LSL  = 5'b10000;
  localparam logic [4:0] FS_LSR  = 5'b10100;
  localparam logic [2:0] K_IMM   = 3'b000;
  localparam logic [2:0] K_MOV   = 3'b100;
  localparam logic [2:0] K_MOVK  = 3'b101;
  localparam logic [2:0] K_SHIFT = 3'b110;
  localparam logic [6:0] OP_LOGIC = 7'b1001000;
  localparam logic [6:0] OP_SHIFT = 7'b1001101;
  localparam logic [4:0] OP_MATHI = 5'b10001;
  localparam logic [5:0] OP_MOV   = 6'b100101;
  typedef struct packed {
    logic [4:0] fs;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic       w_reg;
    logic       c0;
    logic [1:0] mem_cs;
    logic       b_sel;
    logic       mem_write_en;
    logic       ir_load;
    logic       status_load;
    logic [1:0] size;
    logic       add_tri_sel;
    logic [1:0] data_tri_sel;
    logic       pc_sel;
    logic [1:0] pc_fs;
  } cw_t;
endpackage

// File: rtl/cu_imm_decode.sv
// cu_imm_decode: maps latched instruction and execute state to datapath controls; CU_IMM_MOVN_EN adds two-cycle MOVN
module cu_imm_decode
  import cu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0] ir_q,
  input  state_t      state,
  output cw_t         cw,
  output logic [2:0]  k_mux,
  output logic        multi,
  output logic        ill
);
  logic [1:0] opc;
  logic       logic_g, shift_g, math_g, mov_g, movz, movk, movn, ex1, range_bad;
  logic [4:0] fs;
  logic [2:0] k;
  logic       unused_bits;
  assign unused_bits = &{ir_q[31], ir_q[14:10]};
  assign opc = ir_q[30:29];
  assign logic_g = ir_q[28:22] == OP_LOGIC;
  assign shift_g = ir_q[28:22] == OP_SHIFT;
  assign math_g = ir_q[28:24] == OP_MATHI;
  assign mov_g = ir_q[28:23] == OP_MOV;
  assign movz = mov_g && opc == 2'b10;
  assign movk = mov_g && opc == 2'b11;
`ifdef CU_IMM_MOVN_EN
  assign movn = mov_g && opc == 2'b00;
`else
  assign movn = 1'b0;
`endif
  assign range_bad = DATA_W == 32 && ((mov_g && ir_q[22]) || (shift_g && ir_q[15]));
  assign ill = !(logic_g || shift_g || math_g || movz || movk || movn) || range_bad;
  assign ex1 = state == EX1;
  assign multi = state == EX0 && (movk || movn) && !ill;
  assign fs = math_g ? (opc[1] ? FS_SUB : FS_ADD)
            : logic_g ? (opc == 2'b01 ? FS_ORR : opc == 2'b10 ? FS_XOR : FS_AND)
            : shift_g ? (ir_q[21] ? FS_LSL : FS_LSR)
            : (movk && !ex1) ? FS_ANDN
            : (movn && ex1) ? FS_NOTA : FS_ORR;
  assign k = shift_g ? K_SHIFT
           : (movk && !ex1) ? K_MOVK
           : (movn && ex1) ? K_IMM
           : mov_g ? K_MOV : K_IMM;
  // Illegal encodings only advance the PC; IDLE drives an all-zero word
  always_comb begin
    cw = '0;
    k_mux = K_IMM;
    if (state != IDLE && ill) cw.pc_fs = 2'b01;
    else if (state != IDLE) begin
      cw.fs = fs;
      cw.sa = ir_q[9:5];
      cw.sb = ir_q[20:16];
      cw.da = ir_q[4:0];
      cw.w_reg = 1'b1;
      cw.b_sel = 1'b1;
      cw.c0 = math_g && opc[1];
      cw.status_load = (math_g && opc[0]) || (logic_g && opc == 2'b11);
      cw.pc_fs = (movk && !ex1) ? 2'b00 : 2'b01;
      k_mux = k;
    end
  end
endmodule

// File: rtl/cu_imm_seq.sv
// cu_imm_seq: sequenced immediate-class control unit with start/ready/done handshake; CU_IMM_MOVN_EN enables MOVN
module cu_imm_seq
  import cu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CW_W   = 36
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     ir,
  input  logic            stall,
  output logic            ready,
  output logic            done,
  output logic            illegal,
  output logic [CW_W-1:0] control_word,
  output logic [2:0]      k_mux,
  output logic [5:0]      shamt,
  output logic [1:0]      mask_size
);
  state_t      state, state_n;
  logic [31:0] ir_q;
  cw_t         cw;
  logic        multi, ill, fin, accept;
  cu_imm_decode #(.DATA_W(DATA_W)) u_dec (
    .ir_q  (ir_q),
    .state (state),
    .cw    (cw),
    .k_mux (k_mux),
    .multi (multi),
    .ill   (ill)
  );
  // Execute state and latched instruction; an accepted start always lands in EX0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ir_q <= '0;
    end else begin
      state <= state_n;
      if (accept) ir_q <= ir;
    end
  end
  // Handshake and next state; stall freezes any execute cycle in place
  always_comb begin
    fin = ((state == EX0 && !multi) || state == EX1) && !stall;
    ready = state == IDLE || fin;
    accept = start && ready;
    done = fin;
    illegal = fin && ill;
    state_n = accept ? EX0 : stall ? state : (state == EX0 && multi) ? EX1 : IDLE;
  end
  assign control_word = cw;
  assign shamt = ir_q[15:10];
  assign mask_size = ir_q[22:21];
endmodule

// File: tb/tb_cu_imm_seq.sv
// tb_cu_imm_seq: directed table, corner sequences and randomized model check of cu_imm_seq at 64 and 32 bit widths
module tb_cu_imm_seq;
  logic        clock = 1'b0;
  logic        reset, start, stall;
  logic [31:0] ir;
  logic        rdy[2], dn[2], il[2];
  logic [35:0] cwv[2];
  logic [2:0]  km[2];
  logic [5:0]  sh[2];
  logic [1:0]  ms[2];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cu_imm_seq #(.DATA_W(64)) dut (
    .clock(clock), .reset(reset), .start(start), .ir(ir), .stall(stall),
    .ready(rdy[0]), .done(dn[0]), .illegal(il[0]), .control_word(cwv[0]),
    .k_mux(km[0]), .shamt(sh[0]), .mask_size(ms[0])
  );
  cu_imm_seq #(.DATA_W(32)) dut32 (
    .clock(clock), .reset(reset), .start(start), .ir(ir), .stall(stall),
    .ready(rdy[1]), .done(dn[1]), .illegal(il[1]), .control_word(cwv[1]),
    .k_mux(km[1]), .shamt(sh[1]), .mask_size(ms[1])
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_ILL, M_ADDI, M_ADDIS, M_SUBI, M_SUBIS, M_ANDI, M_ORRI, M_EORI, M_ANDIS,
                M_LSL, M_LSR, M_MOVZ, M_MOVK} mn_t;
  typedef struct {
    logic [35:0] cw;
    logic [35:0] m;
    logic [2:0]  k;
    logic        ill;
  } rec_t;
  rec_t        mq[2][2];
  int          mn[2];
  logic [31:0] cur[2];

  function automatic mn_t cls(logic [31:0] x, int dw);
    logic [1:0] o = x[30:29];
    mn_t r = M_ILL;
    if (x[28:24] == 5'b10001)
      r = o == 2'd0 ? M_ADDI : o == 2'd1 ? M_ADDIS : o == 2'd2 ? M_SUBI : M_SUBIS;
    else if (x[28:22] == 7'b1001000)
      r = o == 2'd0 ? M_ANDI : o == 2'd1 ? M_ORRI : o == 2'd2 ? M_EORI : M_ANDIS;
    else if (x[28:22] == 7'b1001101)
      r = (dw == 32 && x[15:10] >= 6'd32) ? M_ILL : x[21] ? M_LSL : M_LSR;
    else if (x[28:23] == 6'b100101 && o >= 2'd2)
      r = (dw == 32 && x[22:21] >= 2'd2) ? M_ILL : o == 2'd2 ? M_MOVZ : M_MOVK;
    return r;
  endfunction

  function automatic rec_t mk(logic [4:0] fs, logic c0, logic sl, logic [1:0] pc, logic [2:0] k, logic [31:0] x);
    rec_t r;
    r.cw = {fs, x[9:5], x[20:16], x[4:0], 1'b1, c0, 2'b00, 1'b1, 2'b00, sl, 6'b0, pc};
    r.m = '1;
    r.k = k;
    r.ill = 1'b0;
    return r;
  endfunction

  task automatic push(input int d, input rec_t r);
    mq[d][mn[d]] = r;
    mn[d]++;
  endtask

  task automatic push_ins(input int d, input logic [31:0] x);
    mn_t  m;
    rec_t bad;
    m = cls(x, d == 0 ? 64 : 32);
    bad.cw = 36'd1;
    bad.m = 36'h8103;
    bad.k = 3'b000;
    bad.ill = 1'b1;
    case (m)
      M_ADDI, M_ADDIS: push(d, mk(5'b01000, 1'b0, m == M_ADDIS, 2'b01, 3'b000, x));
      M_SUBI, M_SUBIS: push(d, mk(5'b01001, 1'b1, m == M_SUBIS, 2'b01, 3'b000, x));
      M_ANDI, M_ANDIS: push(d, mk(5'b00000, 1'b0, m == M_ANDIS, 2'b01, 3'b000, x));
      M_ORRI: push(d, mk(5'b00100, 1'b0, 1'b0, 2'b01, 3'b000, x));
      M_EORI: push(d, mk(5'b01100, 1'b0, 1'b0, 2'b01, 3'b000, x));
      M_LSL:  push(d, mk(5'b10000, 1'b0, 1'b0, 2'b01, 3'b110, x));
      M_LSR:  push(d, mk(5'b10100, 1'b0, 1'b0, 2'b01, 3'b110, x));
      M_MOVZ: push(d, mk(5'b00100, 1'b0, 1'b0, 2'b01, 3'b100, x));
      M_MOVK: begin
        push(d, mk(5'b00001, 1'b0, 1'b0, 2'b00, 3'b101, x));
        push(d, mk(5'b00100, 1'b0, 1'b0, 2'b01, 3'b100, x));
      end
      default: push(d, bad);
    endcase
  endtask

  task automatic model_cycle(input int d);
    logic        busy, last, erdy, edn, eill, kchk;
    logic [35:0] ecw, em;
    logic [2:0]  ek;
    busy = mn[d] > 0;
    last = mn[d] == 1;
    if (busy) begin
      ecw = mq[d][0].cw; em = mq[d][0].m; ek = mq[d][0].k; kchk = !mq[d][0].ill;
      eill = mq[d][0].ill && !stall; edn = last && !stall; erdy = last && !stall;
    end else begin
      ecw = '0; em = '1; ek = 3'b000; kchk = 1'b1; eill = 1'b0; edn = 1'b0; erdy = 1'b1;
    end
    chk($sformatf("rnd%0d control_word", d), cwv[d] & em, ecw & em);
    if (kchk) chk($sformatf("rnd%0d k_mux", d), km[d], ek);
    chk($sformatf("rnd%0d done", d), dn[d], edn);
    chk($sformatf("rnd%0d illegal", d), il[d], eill);
    chk($sformatf("rnd%0d ready", d), rdy[d], erdy);
    chk($sformatf("rnd%0d shamt", d), sh[d], cur[d][15:10]);
    chk($sformatf("rnd%0d mask_size", d), ms[d], cur[d][22:21]);
    if (busy && !stall) begin
      mq[d][0] = mq[d][1];
      mn[d]--;
    end
    if (start && erdy) begin
      cur[d] = ir;
      push_ins(d, ir);
    end
  endtask

  function automatic logic [31:0] rnd_ir();
    logic [31:0] x = $urandom;
    case ($urandom_range(0, 5))
      0: x[28:24] = 5'b10001;
      1: x[28:22] = 7'b1001000;
      2: x[28:22] = 7'b1001101;
      3, 4: x[28:23] = 6'b100101;
      default: ;
    endcase
    return x;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_chk(input string n, input int d);
    chk({n, " cw"}, cwv[d], 36'd0);
    chk({n, " k_mux"}, km[d], 3'b000);
    chk({n, " ready"}, rdy[d], 1'b1);
    chk({n, " done"}, dn[d], 1'b0);
    chk({n, " illegal"}, il[d], 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] ir;
    logic [4:0]  fs;
    logic [2:0]  k;
    logic        c0, sl, ill64, ill32, two;
  } vec_t;
  vec_t tv[19];

  initial begin
    tv[0]  = '{32'h91001441, 5'b01000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{32'hB1001441, 5'b01000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{32'hD1001441, 5'b01001, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{32'hF1001441, 5'b01001, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{32'h92000441, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{32'hB2000441, 5'b00100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{32'hD2000441, 5'b01100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{32'hF2000441, 5'b00000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{32'hD3601041, 5'b10000, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{32'hD3401041, 5'b10100, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[10] = '{32'hD340A041, 5'b10100, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[11] = '{32'hD3407C41, 5'b10100, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[12] = '{32'hD2800003, 5'b00100, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[13] = '{32'hD2C00000, 5'b00100, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[14] = '{32'hF2B7DDE3, 5'b00001, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[15] = '{32'hB2800000, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[16] = '{32'h92800000, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[17] = '{32'h00000000, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[18] = '{32'hF2E00000, 5'b00001, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    reset = 1'b1; start = 1'b0; stall = 1'b0; ir = '0;
    repeat (2) @(posedge clock);
    #1;
    idle_chk("reset dut0", 0);
    idle_chk("reset dut1", 1);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 19; i++) begin
      start = 1'b1; ir = tv[i].ir;
      tick();
      start = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
        logic bad;
        bad = d == 0 ? tv[i].ill64 : tv[i].ill32;
        chk($sformatf("vec%0d/%0d illegal", i, d), il[d], bad);
        chk($sformatf("vec%0d/%0d done", i, d), dn[d], bad || !tv[i].two);
        chk($sformatf("vec%0d/%0d w_reg", i, d), cwv[d][15], !bad);
        chk($sformatf("vec%0d/%0d status_load", i, d), cwv[d][8], !bad && tv[i].sl);
        chk($sformatf("vec%0d/%0d pc_fs", i, d), cwv[d][1:0], (tv[i].two && !bad) ? 2'b00 : 2'b01);
        if (!bad) begin
          chk($sformatf("vec%0d/%0d fs", i, d), cwv[d][35:31], tv[i].fs);
          chk($sformatf("vec%0d/%0d k_mux", i, d), km[d], tv[i].k);
          chk($sformatf("vec%0d/%0d c0", i, d), cwv[d][14], tv[i].c0);
          chk($sformatf("vec%0d/%0d sa", i, d), cwv[d][30:26], tv[i].ir[9:5]);
          chk($sformatf("vec%0d/%0d da", i, d), cwv[d][20:16], tv[i].ir[4:0]);
        end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        logic bad;
        bad = d == 0 ? tv[i].ill64 : tv[i].ill32;
        chk($sformatf("vec%0d/%0d next illegal", i, d), il[d], 1'b0);
        chk($sformatf("vec%0d/%0d next done", i, d), dn[d], tv[i].two && !bad);
      end
      tick();
    end

    // MOVK with three stalled EX0 cycles: done exactly once, three cycles late
    start = 1'b1; ir = 32'hF2B7DDE3;
    tick();
    start = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall fs", cwv[0][35:31], 5'b00001);
      chk("stall k_mux", km[0], 3'b101);
      chk("stall pc_fs", cwv[0][1:0], 2'b00);
      chk("stall done", dn[0], 1'b0);
      chk("stall ready", rdy[0], 1'b0);
      tick();
    end
    stall = 1'b0;
    #1;
    chk("movk ex0 fs", cwv[0][35:31], 5'b00001);
    chk("movk ex0 done", dn[0], 1'b0);
    chk("movk ex0 ready", rdy[0], 1'b0);
    chk("movk mask_size", ms[0], 2'b01);
    tick();
    chk("movk ex1 fs", cwv[0][35:31], 5'b00100);
    chk("movk ex1 k_mux", km[0], 3'b100);
    chk("movk ex1 pc_fs", cwv[0][1:0], 2'b01);
    chk("movk ex1 done", dn[0], 1'b1);
    chk("movk ex1 ready", rdy[0], 1'b1);
    tick();
    idle_chk("movk after", 0);

    // Reset during MOVK EX0 abandons it
    start = 1'b1; ir = 32'hF2B7DDE3;
    tick();
    start = 1'b0;
    #1;
    chk("rst pre fs", cwv[0][35:31], 5'b00001);
    reset = 1'b1;
    #1;
    idle_chk("rst mid", 0);
    tick();
    reset = 1'b0;
    #1;
    idle_chk("rst post", 0);
    tick();
    idle_chk("rst post2", 0);

    // Back-to-back single-cycle ops with start held high
    start = 1'b1; ir = 32'h91001441;
    tick();
    ir = 32'h91001442;
    #1;
    chk("b2b first done", dn[0], 1'b1);
    chk("b2b first ready", rdy[0], 1'b1);
    chk("b2b first da", cwv[0][20:16], 5'd1);
    tick();
    start = 1'b0;
    #1;
    chk("b2b second done", dn[0], 1'b1);
    chk("b2b second ready", rdy[0], 1'b1);
    chk("b2b second da", cwv[0][20:16], 5'd2);
    chk("b2b second fs", cwv[0][35:31], 5'b01000);
    tick();
    idle_chk("b2b after", 0);

    // Randomized run against the reference model
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mn[d] = 0;
      cur[d] = '0;
    end
    tick();
    for (int c = 0; c < 3000; c++) begin
      start = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 4) == 0;
      ir = rnd_ir();
      #1;
      for (int d = 0; d < 2; d++) model_cycle(d);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
